mult_io_sequencer: RTL and testbench

Pin-side front/back end for the 8x8 array multiplier in the TinyTapeout wrapper. It collects two 8-bit operands serially from `ui_in` under a host strobe on `uio_in[0]`, and launches the multiplier with a start/done handshake. The 16-bit product is loaded into, or added to, an accumulator, which is returned byte-serially on `uo_out` under the same strobe. It sits between the top-level pins and the multiplier core, both feeding the core and consuming its result.

---
 rtl/mult_io_pkg.sv | 28 ++
 rtl/sync_edge_det.sv | 34 +++
 rtl/mult_io_sequencer.sv | 142 ++++++++++++++
 tb/tb_mult_io_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_io_pkg.sv
// Shared types and constants for the multiplier pin-side sequencer.
// Bit positions refer to the TinyTapeout uio bus.
package mult_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GET_B,
    MUL,
    OUT
  } state_t;

  localparam int UIO_STRB      = 0;
  localparam int UIO_ACC_EN    = 1;
  localparam int UIO_ACC_CLR   = 2;
  localparam int UIO_BUSY      = 3;
  localparam int UIO_RES_VALID = 4;
  localparam int UIO_OVF       = 5;

  localparam logic [7:0] UIO_OE = 8'h38;

  localparam int ACC_W_DEFAULT     = 24;
  localparam int ACC_BYTES_DEFAULT = ACC_W_DEFAULT / 8;

  function automatic int byte_count(input int acc_w);
    return acc_w / 8;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-bit synchronizer for the uio control bits with a registered,
// enable-gated rising-edge pulse on bit 0.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             rise
);

  logic [WIDTH-1:0] stages [SYNC_STAGES];
  logic             prev;

  // prev tracks the line even while disabled, so edges seen with ena=0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stages[i] <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) stages[i] <= stages[i-1];
      prev <= stages[SYNC_STAGES-1][0];
      rise <= ena & stages[SYNC_STAGES-1][0] & ~prev;
    end
  end

  assign dout = stages[SYNC_STAGES-1];

endmodule

// File: rtl/mult_io_sequencer.sv
// Serial operand collection, multiplier launch and accumulator readback
// between the TinyTapeout pins and the 8x8 multiplier core.
module mult_io_sequencer
  import mult_io_pkg::*;
#(
  parameter int ACC_W       = ACC_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  ui_in,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uo_out,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [15:0] mul_p
);

  localparam int NBYTES = byte_count(ACC_W);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t             state, next_state;
  logic [2:0]         ctrl_sync;
  logic               stb;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_shift;
  logic [ACC_W:0]     sum;
  logic [IDX_W-1:0]   idx;
  logic               ovf;
  logic               acc_en_q;
  logic               pending;
  logic               start_q;
  logic               done_seen;
  logic               take_result;
  logic               last_byte;
  logic               unused_bits;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .WIDTH      (3)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .din  (uio_in[2:0]),
    .dout (ctrl_sync),
    .rise (stb)
  );

  assign unused_bits = ^{uio_in[7:3], ctrl_sync[UIO_STRB]};

  // A done coinciding with the start pulse is not a real result
  always_comb begin
    done_seen   = (state == MUL) && mul_done && !start_q;
    take_result = (state == MUL) && ena && (done_seen || pending);
    sum         = {1'b0, acc} + (ACC_W+1)'(mul_p);
    last_byte   = (idx == IDX_W'(NBYTES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    uo_out     = 8'h00;
    uio_out    = 8'h00;
    uio_oe     = UIO_OE;
    acc_shift  = acc >> {idx, 3'b000};
    case (state)
      IDLE:    if (stb) next_state = GET_B;
      GET_B:   if (stb) next_state = MUL;
      MUL:     if (take_result) next_state = OUT;
      OUT:     if (stb && last_byte) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (state == OUT) uo_out = acc_shift[7:0];
    uio_out[UIO_BUSY]      = (state == GET_B) || (state == MUL);
    uio_out[UIO_RES_VALID] = (state == OUT);
    uio_out[UIO_OVF]       = ovf;
  end

  // Pending holds a done that arrived while disabled until ena returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= 8'h00;
      mul_b    <= 8'h00;
      acc      <= '0;
      ovf      <= 1'b0;
      acc_en_q <= 1'b0;
      pending  <= 1'b0;
      start_q  <= 1'b0;
      idx      <= '0;
    end else begin
      start_q <= (state == GET_B) && stb;
      case (state)
        IDLE: begin
          if (stb) begin
            mul_a <= ui_in;
            if (ctrl_sync[UIO_ACC_CLR]) begin
              acc <= '0;
              ovf <= 1'b0;
            end
          end
        end
        GET_B: begin
          if (stb) begin
            mul_b    <= ui_in;
            acc_en_q <= ctrl_sync[UIO_ACC_EN];
          end
        end
        MUL: begin
          if (take_result) begin
            if (acc_en_q) begin
              acc <= sum[ACC_W-1:0];
              ovf <= ovf | sum[ACC_W];
            end else begin
              acc <= ACC_W'(mul_p);
            end
            idx     <= '0;
            pending <= 1'b0;
          end else if (done_seen) begin
            pending <= 1'b1;
          end
        end
        OUT: begin
          if (stb) idx <= last_byte ? '0 : idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mul_start = start_q;

endmodule

// File: tb/tb_mult_io_sequencer.sv
// Scoreboard bench driving a 24-bit and a 16-bit accumulator instance
// through the serial strobe protocol with a behavioural multiplier stub.
module tb_mult_io_sequencer;

  localparam int NDUT = 2;

  typedef struct {
    int         dut;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct {
    int          dut;
    logic [23:0] acc;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  ui_in;
  logic        strb, acc_en, acc_clr;
  int          sel;

  logic [7:0]  uio_in_d  [NDUT];
  logic [7:0]  uo        [NDUT];
  logic [7:0]  uio_out_d [NDUT];
  logic [7:0]  oe        [NDUT];
  logic [7:0]  ma        [NDUT];
  logic [7:0]  mb        [NDUT];
  logic        ms        [NDUT];
  logic        md        [NDUT];
  logic [15:0] mp        [NDUT];

  int          checks = 0;
  int          errors = 0;

  op_t         op_q[$];
  res_t        res_q[$];
  longint      m_acc [NDUT];
  logic        m_ovf [NDUT];
  logic [7:0]  last_a [NDUT];
  int          delay [NDUT] = '{3, 3};
  bit          suppress [NDUT] = '{1'b0, 1'b0};
  int          inject_req [NDUT] = '{0, 0};

  always #5 clk = ~clk;

  mult_io_sequencer #(.ACC_W(24), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in_d[0]),
    .uo_out(uo[0]), .uio_out(uio_out_d[0]), .uio_oe(oe[0]), .mul_a(ma[0]), .mul_b(mb[0]),
    .mul_start(ms[0]), .mul_done(md[0]), .mul_p(mp[0])
  );

  mult_io_sequencer #(.ACC_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in_d[1]),
    .uo_out(uo[1]), .uio_out(uio_out_d[1]), .uio_oe(oe[1]), .mul_a(ma[1]), .mul_b(mb[1]),
    .mul_start(ms[1]), .mul_done(md[1]), .mul_p(mp[1])
  );

  function automatic int width(input int d);
    return (d == 0) ? 24 : 16;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] data, input logic en, input logic clr);
    ui_in   = data;
    acc_en  = en;
    acc_clr = clr;
    strb    = 1'b1;
    tick(6);
    strb    = 1'b0;
    tick(6);
  endtask

  // Reference model: operands and expected accumulator pushed before the DUT sees them
  task automatic apply_stimulus(input int d, input logic [7:0] a, input logic [7:0] b,
                                input logic en, input logic clr, input bit expect_result);
    longint p, s, m;
    sel = d;
    op_q.push_back('{d, a, b});
    last_a[d] = a;
    if (expect_result) begin
      m = longint'(1) << width(d);
      if (clr) begin
        m_acc[d] = 0;
        m_ovf[d] = 1'b0;
      end
      p = longint'(a) * longint'(b);
      if (en) begin
        s = m_acc[d] + p;
        if (s >= m) m_ovf[d] = 1'b1;
        m_acc[d] = s % m;
      end else begin
        m_acc[d] = p;
      end
      res_q.push_back('{d, 24'(m_acc[d]), m_ovf[d]});
    end
    strobe(a, ~en, clr);
    strobe(b, en, 1'b0);
  endtask

  task automatic read_result(input int d);
    for (int i = 0; i < 300 && !uio_out_d[d][4]; i++) tick(1);
    check_output("res_valid_wait", 32'(uio_out_d[d][4]), 32'd1);
    if (!uio_out_d[d][4]) return;
    for (int k = 0; k < width(d) / 8; k++) strobe(8'h00, 1'b0, 1'b0);
    check_output("back_to_idle", 32'(uio_out_d[d][4:3]), 32'd0);
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : mon
    assign uio_in_d[g] = (sel == g) ? {5'b00000, acc_clr, acc_en, strb} : 8'h00;

    // Multiplier stub: done arrives delay[g] cycles after the start cycle
    initial begin : stub
      int          cnt = 0;
      int          ack = 0;
      logic [15:0] prod = 16'h0000;
      md[g] = 1'b0;
      mp[g] = 16'h0000;
      forever begin
        @(negedge clk);
        md[g] = 1'b0;
        if (inject_req[g] != ack) begin
          ack++;
          md[g] = 1'b1;
          mp[g] = 16'hFFFF;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            md[g] = 1'b1;
            mp[g] = prod;
          end
        end else if (ms[g] === 1'b1 && !suppress[g]) begin
          prod = 16'(ma[g]) * 16'(mb[g]);
          cnt  = delay[g];
        end
      end
    end

    initial begin : start_mon
      logic prev = 1'b0;
      op_t  o;
      forever begin
        @(negedge clk);
        if (ms[g] === 1'b1) begin
          check_output("start_single_cycle", 32'(prev), 32'd0);
          if (op_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL start_unexpected: dut %0d started with no queued operands", g);
          end else begin
            o = op_q.pop_front();
            check_output("op_dut", 32'(g), 32'(o.dut));
            check_output("mul_a", 32'(ma[g]), 32'(o.a));
            check_output("mul_b", 32'(mb[g]), 32'(o.b));
          end
        end
        prev = (ms[g] === 1'b1);
      end
    end

    initial begin : res_mon
      logic prev_rv   = 1'b0;
      logic prev_strb = 1'b0;
      res_t cur;
      int   k = 0;
      cur = '{g, 24'h0, 1'b0};
      forever begin
        @(negedge clk);
        if (uio_out_d[g][4] === 1'b1 && !prev_rv) begin
          if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_unexpected: dut %0d presented a result with none queued", g);
          end else begin
            cur = res_q.pop_front();
            check_output("result_dut", 32'(g), 32'(cur.dut));
            check_output("ovf", 32'(uio_out_d[g][5]), 32'(cur.ovf));
            k = 0;
          end
        end
        if (uio_out_d[g][4] === 1'b1 && uio_in_d[g][0] && !prev_strb) begin
          check_output($sformatf("byte%0d_dut%0d", k, g), 32'(uo[g]), 32'((cur.acc >> (8 * k)) & 24'hFF));
          k++;
        end
        prev_rv   = (uio_out_d[g][4] === 1'b1);
        prev_strb = uio_in_d[g][0];
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] a, b;
    logic       en, clr;
    int         d;

    sel     = 0;
    strb    = 1'b0;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    ui_in   = 8'h00;
    ena     = 1'b1;
    rst_n   = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      m_acc[i]  = 0;
      m_ovf[i]  = 1'b0;
      last_a[i] = 8'h00;
    end
    tick(3);
    for (int i = 0; i < NDUT; i++) begin
      check_output("reset_uo_out", 32'(uo[i]), 32'h00);
      check_output("reset_uio_out", 32'(uio_out_d[i]), 32'h00);
      check_output("reset_uio_oe", 32'(oe[i]), 32'h38);
      check_output("reset_mul_start", 32'(ms[i]), 32'd0);
    end
    rst_n = 1'b1;
    tick(3);

    $display("[TB] load and accumulate, 24-bit");
    apply_stimulus(0, 8'h0F, 8'h11, 1'b0, 1'b1, 1'b1);
    read_result(0);
    apply_stimulus(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    read_result(0);

    $display("[TB] overflow and clear, 16-bit");
    apply_stimulus(1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1);
    read_result(1);
    apply_stimulus(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    read_result(1);
    apply_stimulus(1, 8'h03, 8'h05, 1'b1, 1'b1, 1'b1);
    read_result(1);

    $display("[TB] randomized sequences");
    for (int n = 0; n < 16; n++) begin
      d        = int'($urandom_range(0, 1));
      a        = 8'($urandom);
      b        = 8'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 5) == 0);
      delay[d] = int'($urandom_range(1, 6));
      apply_stimulus(d, a, b, en, clr, 1'b1);
      read_result(d);
    end
    delay[0] = 3;
    delay[1] = 3;

    $display("[TB] enable gating");
    sel = 0;
    ena = 1'b0;
    strobe(8'h55, 1'b0, 1'b0);
    strobe(8'h66, 1'b0, 1'b0);
    ena = 1'b1;
    tick(5);
    check_output("gated_no_capture_busy", 32'(uio_out_d[0][3]), 32'd0);
    check_output("gated_no_capture_mul_a", 32'(ma[0]), 32'(last_a[0]));

    delay[0] = 30;
    apply_stimulus(0, 8'h21, 8'h43, 1'b1, 1'b0, 1'b1);
    ena = 1'b0;
    tick(40);
    check_output("pending_still_mul", 32'(uio_out_d[0][4:3]), 32'b01);
    ena = 1'b1;
    check_output("out_not_before_ena", 32'(uio_out_d[0][4]), 32'd0);
    tick(1);
    check_output("out_after_ena", 32'(uio_out_d[0][4]), 32'd1);
    read_result(0);
    delay[0] = 3;

    $display("[TB] reset during multiply");
    suppress[0] = 1'b1;
    apply_stimulus(0, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    check_output("in_mul_busy", 32'(uio_out_d[0][3]), 32'd1);
    rst_n = 1'b0;
    tick(2);
    check_output("midreset_uo_out", 32'(uo[0]), 32'h00);
    check_output("midreset_uio_out", 32'(uio_out_d[0]), 32'h00);
    check_output("midreset_uio_oe", 32'(oe[0]), 32'h38);
    check_output("midreset_mul_start", 32'(ms[0]), 32'd0);
    check_output("midreset_mul_a", 32'(ma[0]), 32'h00);
    check_output("midreset_mul_b", 32'(mb[0]), 32'h00);
    rst_n = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    inject_req[0] = inject_req[0] + 1;
    tick(5);
    check_output("late_done_idle", 32'(uio_out_d[0]), 32'h00);
    suppress[0] = 1'b0;
    apply_stimulus(0, 8'h10, 8'h10, 1'b1, 1'b0, 1'b1);
    read_result(0);

    tick(5);
    check_output("ops_drained", 32'(op_q.size()), 32'd0);
    check_output("results_drained", 32'(res_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
